// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: S-box geometry and the key-scheduling state encoding.
package arc4_pkg;

  localparam int ARC4_N      = 256;
  localparam int ARC4_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RD_I,
    LD_I,
    RD_J,
    LD_J,
    WR_I,
    WR_J
  } ksa_state_t;

endpackage

// File: rtl/ksa_var_if.sv
// Controller handshake plus single-port S RAM bus for the variable-key KSA engine.
interface ksa_var_if
  import arc4_pkg::*;
#(
  parameter int MAX_KEY_BYTES = 3,
  parameter int KL_W          = $clog2(MAX_KEY_BYTES + 1)
);

  logic                                 en;
  logic                                 rdy;
  logic [ARC4_BYTE_W*MAX_KEY_BYTES-1:0] key;
  logic [KL_W-1:0]                      key_len;
  logic                                 init;
  logic [ARC4_BYTE_W-1:0]               addr;
  logic [ARC4_BYTE_W-1:0]               rddata;
  logic [ARC4_BYTE_W-1:0]               wrdata;
  logic                                 wren;

  // master: controller and RAM side; slave: the KSA engine
  modport master (
    output en, key, key_len, init, rddata,
    input  rdy, addr, wrdata, wren
  );

  modport slave (
    input  en, key, key_len, init, rddata,
    output rdy, addr, wrdata, wren
  );

endinterface

// File: rtl/arc4_key_byte.sv
// Selects key byte k from a big-endian packed key (byte 0 in the top bits).
module arc4_key_byte
  import arc4_pkg::*;
#(
  parameter int MAX_KEY_BYTES = 3,
  parameter int KL_W          = $clog2(MAX_KEY_BYTES + 1)
) (
  input  logic [ARC4_BYTE_W*MAX_KEY_BYTES-1:0] key,
  input  logic [KL_W-1:0]                      k,
  output logic [ARC4_BYTE_W-1:0]               kb
);

  always_comb begin
    kb = '0;
    for (int unsigned b = 0; b < MAX_KEY_BYTES; b++) begin
      if (k == KL_W'(b)) begin
        kb = key[ARC4_BYTE_W*(MAX_KEY_BYTES-1-b) +: ARC4_BYTE_W];
      end
    end
  end

endmodule

// File: rtl/ksa_var.sv
// ARC4 key-scheduling engine for run-time key lengths 1..MAX_KEY_BYTES, with an
// optional identity fill of S before the swap pass. Six cycles per swap iteration.
module ksa_var
  import arc4_pkg::*;
#(
  parameter int MAX_KEY_BYTES = 3,
  parameter int KL_W          = $clog2(MAX_KEY_BYTES + 1)
) (
  input  logic     clk,
  input  logic     rst,
  ksa_var_if.slave bus
);

  typedef logic [ARC4_BYTE_W-1:0] byte_t;

  localparam logic [KL_W-1:0] MAX_LEN = KL_W'(MAX_KEY_BYTES);
  localparam byte_t           LAST    = byte_t'(ARC4_N - 1);

  ksa_state_t                           state;
  logic [ARC4_BYTE_W*MAX_KEY_BYTES-1:0] key_q;
  logic [KL_W-1:0]                      len_q;
  logic [KL_W-1:0]                      k;
  logic [KL_W-1:0]                      k_inc;
  logic [KL_W-1:0]                      k_next;
  byte_t                                i;
  byte_t                                j;
  byte_t                                si;
  byte_t                                kb;
  byte_t                                j_new;
  logic                                 rdy_q;
  logic                                 wren_q;
  byte_t                                addr_q;
  byte_t                                wrdata_q;

  arc4_key_byte #(
    .MAX_KEY_BYTES(MAX_KEY_BYTES),
    .KL_W         (KL_W)
  ) u_key_byte (
    .key(key_q),
    .k  (k),
    .kb (kb)
  );

  // Key index wraps by compare against the latched length instead of a modulo.
  assign k_inc  = k + 1'b1;
  assign k_next = (k_inc == len_q) ? '0 : k_inc;
  assign j_new  = j + bus.rddata + kb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      key_q    <= '0;
      len_q    <= '0;
      k        <= '0;
      i        <= '0;
      j        <= '0;
      si       <= '0;
      rdy_q    <= 1'b1;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      wrdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en) begin
            key_q    <= bus.key;
            len_q    <= (bus.key_len == '0 || bus.key_len > MAX_LEN) ? MAX_LEN : bus.key_len;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            rdy_q    <= 1'b0;
            addr_q   <= '0;
            wrdata_q <= '0;
            wren_q   <= bus.init;
            state    <= bus.init ? FILL : RD_I;
          end
        end
        FILL: begin
          if (i == LAST) begin
            i      <= '0;
            addr_q <= '0;
            wren_q <= 1'b0;
            state  <= RD_I;
          end else begin
            i        <= i + 1'b1;
            addr_q   <= i + 1'b1;
            wrdata_q <= i + 1'b1;
          end
        end
        RD_I: state <= LD_I;
        LD_I: begin
          si     <= bus.rddata;
          j      <= j_new;
          addr_q <= j_new;
          state  <= RD_J;
        end
        RD_J: state <= LD_J;
        // Outputs are loaded one state early so the RAM bus stays fully registered.
        LD_J: begin
          addr_q   <= i;
          wrdata_q <= bus.rddata;
          wren_q   <= 1'b1;
          state    <= WR_I;
        end
        WR_I: begin
          addr_q   <= j;
          wrdata_q <= si;
          state    <= WR_J;
        end
        WR_J: begin
          wren_q <= 1'b0;
          if (i == LAST) begin
            addr_q   <= '0;
            wrdata_q <= '0;
            rdy_q    <= 1'b1;
            state    <= IDLE;
          end else begin
            i      <= i + 1'b1;
            addr_q <= i + 1'b1;
            k      <= k_next;
            state  <= RD_I;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rdy    = rdy_q;
  assign bus.wren   = wren_q;
  assign bus.addr   = addr_q;
  assign bus.wrdata = wrdata_q;

endmodule
